// File: rtl/bcd_converter_bin.sv
// bcd_converter_bin: 3-digit BCD to 8-bit binary converter using reverse double-dabble.
// Ports:
//   clk   - clock, all state updates on the rising edge
//   rst   - asynchronous active-high reset
//   start - conversion request, sampled only in IDLE
//   hunds, tens, units - BCD digits, sampled together with start
//   bin   - binary result, held until the next accepted start
//   busy  - high while converting or presenting the result (SHIFT/DONE)
//   done  - one-cycle pulse marking bin/err valid
//   err   - high when the last accepted request was invalid (value > 255 or non-BCD digit)
module bcd_converter_bin (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] hunds,
    input  logic [3:0] tens,
    input  logic [3:0] units,
    output logic [7:0] bin,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int unsigned DIGITS = 3;
    localparam int unsigned DIG_W  = 4;
    localparam int unsigned BCD_W  = DIGITS * DIG_W;
    localparam int unsigned BIN_W  = 8;
    localparam int unsigned CNT_W  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_n;
    logic [BCD_W-1:0]   bcd_q, bcd_n;
    logic [BIN_W-1:0]   sr_q, sr_n;
    logic [CNT_W-1:0]   cnt_q, cnt_n;
    logic [BIN_W-1:0]   bin_n;
    logic               busy_n, done_n, err_n;

    logic               req_valid_c;
    logic [BCD_W+BIN_W-1:0] shifted_c;
    logic [BCD_W-1:0]   bcd_adj_c;

    // Request is valid only for proper BCD digits with a value of at most 255.
    always_comb begin
        req_valid_c = (hunds <= 4'd9) && (tens <= 4'd9) && (units <= 4'd9) &&
                      ((hunds < 4'd2) ||
                       ((hunds == 4'd2) && ((tens < 4'd5) ||
                                            ((tens == 4'd5) && (units <= 4'd5)))));
    end

    // One reverse double-dabble step: shift right, then correct digits >= 8 by -3.
    always_comb begin
        shifted_c = {bcd_q, sr_q} >> 1;
        bcd_adj_c = shifted_c[BCD_W+BIN_W-1:BIN_W];
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (shifted_c[BIN_W + i*DIG_W +: DIG_W] >= 4'd8)
                bcd_adj_c[i*DIG_W +: DIG_W] = shifted_c[BIN_W + i*DIG_W +: DIG_W] - 4'd3;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n = state_q;
        bcd_n   = bcd_q;
        sr_n    = sr_q;
        cnt_n   = cnt_q;
        bin_n   = bin;
        err_n   = err;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (req_valid_c) begin
                        bcd_n   = {hunds, tens, units};
                        sr_n    = '0;
                        cnt_n   = '0;
                        err_n   = 1'b0;
                        state_n = SHIFT;
                    end else begin
                        bin_n   = '0;
                        err_n   = 1'b1;
                        state_n = DONE;
                    end
                end
            end
            SHIFT: begin
                bcd_n = bcd_adj_c;
                sr_n  = shifted_c[BIN_W-1:0];
                cnt_n = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(BIN_W - 1)) begin
                    bin_n   = shifted_c[BIN_W-1:0];
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
        done_n = (state_n == DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            bcd_q   <= '0;
            sr_q    <= '0;
            cnt_q   <= '0;
            bin     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state_q <= state_n;
            bcd_q   <= bcd_n;
            sr_q    <= sr_n;
            cnt_q   <= cnt_n;
            bin     <= bin_n;
            busy    <= busy_n;
            done    <= done_n;
            err     <= err_n;
        end
    end

endmodule

// File: tb/tb_bcd_converter_bin.sv
// Testbench for bcd_converter_bin: directed and randomized requests checked against
// an arithmetic reference model (value = 100*h + 10*t + u, invalid if non-BCD or > 255).
module tb_bcd_converter_bin;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] hunds, tens, units;
    logic [7:0] bin;
    logic       busy, done, err;

    int n_checks;
    int n_fail;

    bcd_converter_bin dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .hunds (hunds),
        .tens  (tens),
        .units (units),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and follow it to completion. Digits are scrambled every cycle
    // after sampling; if inject > 0 a second start is pulsed on that SHIFT cycle.
    task automatic do_conv(input int h, input int t, input int u, input int inject);
        int         v;
        bit         inv;
        int         lat;
        logic [7:0] eb;
        v   = 100*h + 10*t + u;
        inv = (h > 9) || (t > 9) || (u > 9) || (v > 255);
        lat = inv ? 0 : 8;
        eb  = inv ? 8'h00 : 8'(v);

        hunds = 4'(h);
        tens  = 4'(t);
        units = 4'(u);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_accept", 32'(busy), 32'd1);
        check("done_at_k", 32'(done), 32'(lat == 0));

        for (int n = 1; n <= lat; n++) begin
            hunds = 4'($urandom_range(0, 15));
            tens  = 4'($urandom_range(0, 15));
            units = 4'($urandom_range(0, 15));
            start = (n == inject);
            tick();
            check("done_timing", 32'(done), 32'(n == lat));
            check("busy_active", 32'(busy), 32'd1);
        end
        start = 1'b0;
        check("bin_result", 32'(bin), 32'(eb));
        check("err_result", 32'(err), 32'(inv));

        tick();
        check("done_single", 32'(done), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
        check("bin_held", 32'(bin), 32'(eb));
        check("err_held", 32'(err), 32'(inv));
    endtask

    initial begin
        int cnt_inv;
        n_checks = 0;
        n_fail   = 0;
        rst   = 1'b1;
        start = 1'b0;
        hunds = 4'd0;
        tens  = 4'd0;
        units = 4'd0;

        // Reset state before any clock edge.
        #2;
        check("rst_bin", 32'(bin), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        tick();
        rst = 1'b0;

        // Maximum value, accepted on the first edge after reset release.
        do_conv(2, 5, 5, 0);

        // Directed sweep.
        do_conv(1, 2, 8, 0);
        do_conv(0, 0, 0, 0);
        do_conv(1, 2, 7, 0);
        do_conv(0, 9, 9, 0);

        // Invalid requests.
        do_conv(2, 5, 6, 0);
        do_conv(0, 10, 0, 0);

        // Extra start during SHIFT must be ignored.
        do_conv(1, 7, 3, 3);

        // Back-to-back with start held high: accepted every 10 cycles.
        hunds = 4'd0;
        tens  = 4'd0;
        units = 4'd7;
        start = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            check("b2b_done", 32'(done), 32'((i == 9) || (i == 19) || (i == 29)));
            if (i == 9 || i == 19 || i == 29)
                check("b2b_bin", 32'(bin), 32'd7);
        end
        start = 1'b0;
        tick();
        check("b2b_idle", 32'(busy), 32'd0);

        // Reset in the middle of SHIFT aborts the conversion.
        hunds = 4'd1;
        tens  = 4'd2;
        units = 4'd8;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_bin", 32'(bin), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_err", 32'(err), 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("post_rst_nodone", 32'(done), 32'd0);
        end
        do_conv(0, 4, 2, 0);

        // Every valid value.
        for (int v = 0; v < 256; v++)
            do_conv(v / 100, (v / 10) % 10, v % 10, 0);

        // Random invalid codes.
        cnt_inv = 0;
        while (cnt_inv < 20) begin
            int h, t, u;
            h = int'($urandom_range(0, 15));
            t = int'($urandom_range(0, 15));
            u = int'($urandom_range(0, 15));
            if ((h > 9) || (t > 9) || (u > 9) || (100*h + 10*t + u > 255)) begin
                do_conv(h, t, u, 0);
                cnt_inv++;
            end
        end

        // Random mix with stray starts during SHIFT.
        for (int i = 0; i < 20; i++)
            do_conv(int'($urandom_range(0, 2)), int'($urandom_range(0, 9)),
                    int'($urandom_range(0, 9)), int'($urandom_range(1, 7)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_converter_bin.md
BCD_CONVERTER_BIN -- requirements
Module: bcd_converter_bin

Interface
REQ-001 The block SHALL have no parameters; the digit count is fixed at 3 and the result width at 8 bits.
REQ-002 clk  input  1  Single clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  Reset, asynchronous and active-high.
REQ-004 start  input  1  Request to convert; sampled only in IDLE.
REQ-005 hunds  input  4  BCD hundreds digit; sampled with start.
REQ-006 tens  input  4  BCD tens digit; sampled with start.
REQ-007 units  input  4  BCD units digit; sampled with start.
REQ-008 bin  output  8  Binary result; registered and held until the next accepted start.
REQ-009 busy  output  1  High while the block is in SHIFT or DONE.
REQ-010 done  output  1  One-cycle pulse marking bin/err valid.
REQ-011 err  output  1  Registered; high when the last accepted request was invalid.

Function
REQ-012 The FSM SHALL have exactly 3 states: IDLE, SHIFT and DONE.
REQ-013 IDLE, start=1, request valid:
  - Capture the 3 digits into a 12-bit BCD register.
  - Clear the 8-bit binary shift register.
  - Set the iteration count to 0, clear err, and go to SHIFT.
REQ-014 A request SHALL be invalid if any of these is true:
  - any digit >9;
  - hunds >2;
  - hunds=2 and tens >5;
  - hunds=2, tens=5 and units >5.
  In short, any request whose value is >255.
REQ-015 IDLE, start=1, request invalid: go directly to DONE, set err=1 and bin=8'h00.
REQ-016 SHIFT, each cycle, one reverse double-dabble iteration:
  - Shift {bcd, binary} right by 1; the bcd LSB enters the binary MSB.
  - Then, for each of the 3 shifted digits: if digit >=8, subtract 3.
REQ-017 SHIFT SHALL perform exactly 8 iterations; on the 8th it SHALL go to DONE and load bin with the final binary value.
REQ-018 DONE SHALL last exactly 1 cycle, with done=1, and then return to IDLE unconditionally.
REQ-019 Latency, with start sampled at edge k:
  - valid request: done=1 in the cycle following edge k+8;
  - invalid request: done=1 in the cycle following edge k.
REQ-020 start SHALL be ignored in SHIFT and DONE; no queuing and no effect on the conversion in progress.
REQ-021 Back-to-back: start held high SHALL be accepted again in the first IDLE cycle after DONE, giving a minimum spacing of 10 cycles between accepted valid starts.
REQ-022 Digit inputs SHALL be ignored outside the sampling cycle; changes during SHIFT SHALL NOT affect the result.
REQ-023 bin and err SHALL remain stable from DONE until the next accepted start.
REQ-024 done SHALL never be high in IDLE or SHIFT.
REQ-025 busy SHALL be 0 only in IDLE.

Reset
REQ-026 While rst=1, regardless of clk:
  - state=IDLE;
  - bin=8'h00, done=0, busy=0, err=0;
  - internal BCD register, binary register and count cleared.
REQ-027 Reset asserted mid-SHIFT SHALL abort the conversion; after release, no done pulse SHALL occur until a new start is accepted.
REQ-028 The first rising edge after reset deassertion SHALL be able to accept start.

Verification
REQ-029 hunds=2, tens=5, units=5, start 1 cycle -> busy=1 for 9 cycles; done 1 cycle after edge k+8; bin=8'hFF; err=0.
REQ-030 Sweep of 1,2,8 / 0,0,0 / 1,2,7 / 0,9,9 -> bin=8'h80 / 8'h00 / 8'h7F / 8'h63 respectively; err=0 for each.
REQ-031 Invalid inputs 2,5,6 and 0,10,0 -> done 1 cycle after edge k; err=1; bin=8'h00; busy high for 1 cycle.
REQ-032 Start pulsed again at cycle 3 of SHIFT with different digits -> ignored; result matches the first request; exactly one done pulse.
REQ-033 rst asserted at SHIFT iteration 4 -> outputs 0 immediately; no done pulse; new start of 0,4,2 -> bin=8'h2A.
REQ-034 Exhaustive check over all 256 valid values plus random invalid codes -> bin equals 100*hunds+10*tens+units, err correct, latency per REQ-019.
